mem_channel_arbiter: RTL and testbench
======================================

# mem_channel_arbiter

Round-robin arbiter sharing NUM_CHANNELS ports of the external asynchronous data memory among NUM_CONSUMERS LSU requesters. It sits between the per-core LSU pass-through registers and the data-memory pins of the gpu top, alongside the program-memory path. One valid/ready four-phase handshake runs on each side, with starvation-free grant order across all LSUs.

## Interface
- ADDR_BITS, 8, memory address width
- DATA_BITS, 8, memory data width
- NUM_CONSUMERS, 8, LSU requesters (NUM_CORES*THREADS_PER_BLOCK)
- NUM_CHANNELS, 4, external memory channels

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- consumer_read_valid  in  [NUM_CONSUMERS]  read request per LSU
- consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS  read address, stable while valid
- consumer_read_ready  out  [NUM_CONSUMERS]  read data valid/ack
- consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  returned read data
- consumer_write_valid  in  [NUM_CONSUMERS]  write request per LSU
- consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
- consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write ack
- mem_read_valid  out  [NUM_CHANNELS]  channel read request
- mem_read_address  out  ADDR_BITS x NUM_CHANNELS
- mem_read_ready  in  [NUM_CHANNELS]  memory read done
- mem_read_data  in  DATA_BITS x NUM_CHANNELS
- mem_write_valid  out  [NUM_CHANNELS]
- mem_write_address  out  ADDR_BITS x NUM_CHANNELS
- mem_write_data  out  DATA_BITS x NUM_CHANNELS
- mem_write_ready  in  [NUM_CHANNELS]  memory write done
- timeout_err  out  1  sticky watchdog error (see Configuration)

## Operation
- Per-channel FSM: IDLE -> READ_WAIT or WRITE_WAIT -> RELEASE -> IDLE.
- Grant in IDLE: channels are evaluated in ascending index in one cycle. Each picks the first requesting, unclaimed consumer at or after rr_ptr, wrapping modulo NUM_CONSUMERS.
- A claim mask prevents two channels from taking the same consumer. Claims made earlier in the same cycle are visible to higher-index channels.
- rr_ptr becomes (last consumer granted this cycle + 1) mod NUM_CONSUMERS; it is unchanged if nothing was granted.
- If read and write valid are both high on one consumer, the read is served first.
- On grant, the channel latches consumer id, address and write data, and asserts mem_read_valid or mem_write_valid.
- READ_WAIT: on mem_read_ready, latch mem_read_data into consumer_read_data[id], set consumer_read_ready[id], drop mem_read_valid, go to RELEASE.
- WRITE_WAIT: on mem_write_ready, set consumer_write_ready[id], drop mem_write_valid, go to RELEASE.
- RELEASE: when the consumer's valid for that op is low, clear its ready and its claim, then go to IDLE.
- consumer_*_data holds its last value until overwritten.

## Timing
- Reset values: all ready/valid outputs 0, address/data outputs 0, rr_ptr 0, all channels IDLE, claim mask 0, timeout_err 0.
- Reset asserted mid-transaction aborts immediately with no completion to the consumer.
- Request sampled high at edge N gives mem_*_valid high after edge N (1-cycle grant latency).
- mem_*_ready sampled at edge M gives consumer ready high after M and mem valid low after M.
- Consumer valid sampled low at edge K gives ready low and the channel IDLE after K. The channel can regrant at edge K+1, so the minimum channel turnaround is 3 cycles with zero-latency memory.
- More requests than free channels: the excess waits; no request is dropped.
- A consumer already claimed is never regranted until its RELEASE completes.

## Configuration
- ARB_TIMEOUT_EN defined:
  - Each channel runs an 8-bit wait counter in READ_WAIT/WRITE_WAIT.
  - When the counter reaches TIMEOUT_CYCLES (255), the channel completes the op anyway. Read data returns 0.
  - timeout_err is set sticky until reset.
- Not defined: no counters; timeout_err is tied to 0; channels wait indefinitely.

## Structure
- Shared package gpu_mem_pkg: channel state enum (IDLE, READ_WAIT, WRITE_WAIT, RELEASE), TIMEOUT_CYCLES constant.
- Sub-module mem_rr_pick: combinational round-robin picker. Inputs are request mask, claim mask and start pointer; outputs are found flag and index. It is instantiated once per channel in a chain.

## Test plan
- Single read: consumer 3 reads addr 0x10, memory returns 0xAB after 2 cycles -> channel 0 serves it; consumer_read_ready[3]=1 with data 0xAB; ready drops 1 cycle after valid drops.
- Oversubscription: all 8 consumers read simultaneously with 4 channels -> consumers 0-3 granted first, then 4-7 after release; rr_ptr=4 after the first round.
- Fairness: consumers 0 and 5 request continuously -> grants alternate 0,5,0,5; neither starves.
- Read+write same consumer: consumer 2 asserts both -> read completes first, then write to 0x20 data 0x55 appears on a channel.
- Reset mid-op: assert reset during READ_WAIT -> all mem valids and consumer readies 0 immediately; rr_ptr 0.
- ARB_TIMEOUT_EN: never assert mem_read_ready -> after 255 wait cycles consumer ready=1, data 0x00, timeout_err=1 and sticky.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared channel-state type and timeout constant for the data-memory arbiter.
package gpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELEASE    = 2'd3
  } ch_state_e;

  localparam logic [7:0] TIMEOUT_CYCLES = 8'd255;

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: first requesting, unclaimed index at or
// after start, wrapping modulo N.
module mem_rr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     claim,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  logic [N-1:0]   avail_s;
  logic [IDX_W:0] pos_s;
  logic           hit_s;

  assign avail_s = req & ~claim;

  // Scan upward from start with wraparound; the first free requester wins
  always_comb begin
    found = 1'b0;
    idx   = start;
    pos_s = '0;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos_s = {1'b0, start} + (IDX_W+1)'(k);
      pos_s = (pos_s >= N_W) ? (pos_s - N_W) : pos_s;
      hit_s = !found && avail_s[pos_s[IDX_W-1:0]];
      idx   = hit_s ? pos_s[IDX_W-1:0] : idx;
      found = found | hit_s;
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter sharing NUM_CHANNELS data-memory channels among LSU requesters.
// Optional watchdog per channel enabled by defining ARB_TIMEOUT_EN.
module mem_channel_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]  mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]  mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
  output logic [DATA_BITS-1:0]     mem_write_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_write_ready,
  output logic                     timeout_err
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [IDX_W-1:0]         LAST_IDX    = IDX_W'(NUM_CONSUMERS - 1);
  localparam logic [NUM_CONSUMERS-1:0] ONE_HOT_LSB = NUM_CONSUMERS'(1);

  ch_state_e                state_r [NUM_CHANNELS];
  logic [IDX_W-1:0]         id_r [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  wr_op_r;
  logic [NUM_CONSUMERS-1:0] claim_r;
  logic [IDX_W-1:0]         rr_ptr_r;
  logic [IDX_W-1:0]         rr_next_s;
  logic [NUM_CONSUMERS-1:0] req_s;
  logic [NUM_CHANNELS-1:0]  grant_s;
  logic [IDX_W-1:0]         grant_idx_s [NUM_CHANNELS];

  assign req_s = consumer_read_valid | consumer_write_valid;

  // Claims ripple from channel 0 upward so one consumer never lands on two channels
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic [NUM_CONSUMERS-1:0] claim_in_s;
    logic [NUM_CONSUMERS-1:0] claim_out_s;
    logic                     found_s;
    logic                     grant_loc_s;
    logic [IDX_W-1:0]         idx_s;

    if (c == 0) begin : g_head
      assign claim_in_s = claim_r;
    end else begin : g_link
      assign claim_in_s = g_chan[c-1].claim_out_s;
    end

    mem_rr_pick #(
      .N     (NUM_CONSUMERS),
      .IDX_W (IDX_W)
    ) u_pick (
      .req   (req_s),
      .claim (claim_in_s),
      .start (rr_ptr_r),
      .found (found_s),
      .idx   (idx_s)
    );

    assign grant_loc_s    = (state_r[c] == IDLE) && found_s;
    assign claim_out_s    = grant_loc_s ? (claim_in_s | (ONE_HOT_LSB << idx_s)) : claim_in_s;
    assign grant_s[c]     = grant_loc_s;
    assign grant_idx_s[c] = idx_s;
  end

  // Pointer moves past the consumer granted by the highest-index granting channel
  always_comb begin
    rr_next_s = rr_ptr_r;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rr_next_s = grant_s[c] ? ((grant_idx_s[c] == LAST_IDX) ? '0 : grant_idx_s[c] + IDX_W'(1))
                             : rr_next_s;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_r [NUM_CHANNELS];
  logic       timeout_err_r;
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

  // Channel state machines with their registered memory- and consumer-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_r[c]           <= IDLE;
        id_r[c]              <= '0;
        mem_read_address[c]  <= '0;
        mem_write_address[c] <= '0;
        mem_write_data[c]    <= '0;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_r[c]        <= 8'd0;
`endif
      end
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        consumer_read_data[k] <= '0;
      end
      wr_op_r              <= '0;
      mem_read_valid       <= '0;
      mem_write_valid      <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      claim_r              <= '0;
      rr_ptr_r             <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_err_r        <= 1'b0;
`endif
    end else begin
      rr_ptr_r <= rr_next_s;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state_r[c])
          IDLE: begin
            if (grant_s[c]) begin
              id_r[c]                 <= grant_idx_s[c];
              claim_r[grant_idx_s[c]] <= 1'b1;
`ifdef ARB_TIMEOUT_EN
              wait_cnt_r[c]           <= 8'd0;
`endif
              // Reads take priority when a consumer raises both
              if (consumer_read_valid[grant_idx_s[c]]) begin
                wr_op_r[c]          <= 1'b0;
                state_r[c]          <= READ_WAIT;
                mem_read_valid[c]   <= 1'b1;
                mem_read_address[c] <= consumer_read_address[grant_idx_s[c]];
              end else begin
                wr_op_r[c]           <= 1'b1;
                state_r[c]           <= WRITE_WAIT;
                mem_write_valid[c]   <= 1'b1;
                mem_write_address[c] <= consumer_write_address[grant_idx_s[c]];
                mem_write_data[c]    <= consumer_write_data[grant_idx_s[c]];
              end
            end
          end
          READ_WAIT: begin
            if (mem_read_ready[c]) begin
              consumer_read_data[id_r[c]]  <= mem_read_data[c];
              consumer_read_ready[id_r[c]] <= 1'b1;
              mem_read_valid[c]            <= 1'b0;
              state_r[c]                   <= RELEASE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (wait_cnt_r[c] == TIMEOUT_CYCLES) begin
              consumer_read_data[id_r[c]]  <= '0;
              consumer_read_ready[id_r[c]] <= 1'b1;
              mem_read_valid[c]            <= 1'b0;
              state_r[c]                   <= RELEASE;
              timeout_err_r                <= 1'b1;
            end else begin
              wait_cnt_r[c] <= wait_cnt_r[c] + 8'd1;
            end
`endif
          end
          WRITE_WAIT: begin
            if (mem_write_ready[c]) begin
              consumer_write_ready[id_r[c]] <= 1'b1;
              mem_write_valid[c]            <= 1'b0;
              state_r[c]                    <= RELEASE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (wait_cnt_r[c] == TIMEOUT_CYCLES) begin
              consumer_write_ready[id_r[c]] <= 1'b1;
              mem_write_valid[c]            <= 1'b0;
              state_r[c]                    <= RELEASE;
              timeout_err_r                 <= 1'b1;
            end else begin
              wait_cnt_r[c] <= wait_cnt_r[c] + 8'd1;
            end
`endif
          end
          RELEASE: begin
            if (wr_op_r[c] ? !consumer_write_valid[id_r[c]] : !consumer_read_valid[id_r[c]]) begin
              if (wr_op_r[c]) begin
                consumer_write_ready[id_r[c]] <= 1'b0;
              end else begin
                consumer_read_ready[id_r[c]] <= 1'b0;
              end
              claim_r[id_r[c]] <= 1'b0;
              state_r[c]       <= IDLE;
            end
          end
          default: begin
            state_r[c] <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed, table-driven bench for mem_channel_arbiter (default parameters).
module tb_mem_channel_arbiter;

  localparam int NC  = 8;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [NC-1:0]  rd_valid;
  logic [7:0]     rd_addr [NC];
  logic [NC-1:0]  rd_ready;
  logic [7:0]     rd_data [NC];
  logic [NC-1:0]  wr_valid;
  logic [7:0]     wr_addr [NC];
  logic [7:0]     wr_data [NC];
  logic [NC-1:0]  wr_ready;
  logic [NCH-1:0] m_rd_valid;
  logic [7:0]     m_rd_addr [NCH];
  logic [NCH-1:0] m_rd_ready;
  logic [7:0]     m_rd_data [NCH];
  logic [NCH-1:0] m_wr_valid;
  logic [7:0]     m_wr_addr [NCH];
  logic [7:0]     m_wr_data [NCH];
  logic [NCH-1:0] m_wr_ready;
  logic           timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_channel_arbiter dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rd_valid),
    .consumer_read_address  (rd_addr),
    .consumer_read_ready    (rd_ready),
    .consumer_read_data     (rd_data),
    .consumer_write_valid   (wr_valid),
    .consumer_write_address (wr_addr),
    .consumer_write_data    (wr_data),
    .consumer_write_ready   (wr_ready),
    .mem_read_valid         (m_rd_valid),
    .mem_read_address       (m_rd_addr),
    .mem_read_ready         (m_rd_ready),
    .mem_read_data          (m_rd_data),
    .mem_write_valid        (m_wr_valid),
    .mem_write_address      (m_wr_addr),
    .mem_write_data         (m_wr_data),
    .mem_write_ready        (m_wr_ready),
    .timeout_err            (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [3:0] exp_valid;
    logic [2:0] id [4];
  } vec_t;

  vec_t tv [10];

  function automatic vec_t mk(input logic [7:0] req, input logic [3:0] v,
                              input logic [2:0] i0, input logic [2:0] i1,
                              input logic [2:0] i2, input logic [2:0] i3);
    vec_t t;
    t.req = req; t.exp_valid = v;
    t.id[0] = i0; t.id[1] = i1; t.id[2] = i2; t.id[3] = i3;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_rdy;
    int         cnt;

    // rr_ptr walks 0 -> 4 -> 0 -> 4 -> 1 -> 1 -> 3 -> 2 -> 2 -> 5 -> 1 through this table
    tv[0] = mk(8'h08, 4'b0001, 3'd3, 3'd0, 3'd0, 3'd0);
    tv[1] = mk(8'hFF, 4'b1111, 3'd4, 3'd5, 3'd6, 3'd7);
    tv[2] = mk(8'hFF, 4'b1111, 3'd0, 3'd1, 3'd2, 3'd3);
    tv[3] = mk(8'h21, 4'b0011, 3'd5, 3'd0, 3'd0, 3'd0);
    tv[4] = mk(8'h21, 4'b0011, 3'd5, 3'd0, 3'd0, 3'd0);
    tv[5] = mk(8'h06, 4'b0011, 3'd1, 3'd2, 3'd0, 3'd0);
    tv[6] = mk(8'h83, 4'b0111, 3'd7, 3'd0, 3'd1, 3'd0);
    tv[7] = mk(8'h00, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);
    tv[8] = mk(8'h1C, 4'b0111, 3'd2, 3'd3, 3'd4, 3'd0);
    tv[9] = mk(8'h61, 4'b0111, 3'd5, 3'd6, 3'd0, 3'd0);

    reset = 1'b1;
    rd_valid = 8'h00; wr_valid = 8'h00; m_rd_ready = 4'h0; m_wr_ready = 4'h0;
    for (int i = 0; i < NC; i++) begin
      rd_addr[i] = 8'h40 + 8'(i); wr_addr[i] = 8'h80 + 8'(i); wr_data[i] = 8'h00;
    end
    for (int c = 0; c < NCH; c++) m_rd_data[c] = 8'h00;
    step();
    check("rst_mem_rd_valid", 32'(m_rd_valid), 32'h0);
    check("rst_mem_wr_valid", 32'(m_wr_valid), 32'h0);
    check("rst_cons_ready", 32'({rd_ready, wr_ready}), 32'h0);
    check("rst_rd_data3", 32'(rd_data[3]), 32'h0);
    check("rst_mem_addr0", 32'(m_rd_addr[0]), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    reset = 1'b0;
    step();

    // Single read, memory answers two cycles late
    rd_addr[3] = 8'h10; rd_valid = 8'h08;
    step();
    check("sr_mem_valid", 32'(m_rd_valid), 32'h1);
    check("sr_mem_addr", 32'(m_rd_addr[0]), 32'h10);
    step(); step();
    check("sr_waiting_ready", 32'(rd_ready), 32'h0);
    m_rd_ready = 4'b0001; m_rd_data[0] = 8'hAB;
    step();
    m_rd_ready = 4'b0000;
    check("sr_cons_ready", 32'(rd_ready), 32'h08);
    check("sr_cons_data", 32'(rd_data[3]), 32'hAB);
    check("sr_mem_valid_low", 32'(m_rd_valid), 32'h0);
    step();
    check("sr_ready_held", 32'(rd_ready), 32'h08);
    rd_valid = 8'h00;
    step();
    check("sr_ready_drop", 32'(rd_ready), 32'h0);
    rd_addr[3] = 8'h43;

    reset = 1'b1; step(); reset = 1'b0; step();

    // Oversubscription: 0-3 first, 4-7 once channels free up
    rd_valid = 8'hFF;
    step();
    check("os_valid_r1", 32'(m_rd_valid), 32'hF);
    for (int c = 0; c < NCH; c++) check("os_addr_r1", 32'(m_rd_addr[c]), 32'h40 + 32'(c));
    for (int c = 0; c < NCH; c++) m_rd_data[c] = m_rd_addr[c] ^ 8'hA5;
    m_rd_ready = 4'hF;
    step();
    m_rd_ready = 4'h0;
    check("os_ready_r1", 32'(rd_ready), 32'h0F);
    rd_valid = 8'hF0;
    step();
    check("os_release", 32'({m_rd_valid, rd_ready}), 32'h0);
    step();
    check("os_valid_r2", 32'(m_rd_valid), 32'hF);
    for (int c = 0; c < NCH; c++) check("os_addr_r2", 32'(m_rd_addr[c]), 32'h44 + 32'(c));
    for (int c = 0; c < NCH; c++) m_rd_data[c] = m_rd_addr[c] ^ 8'hA5;
    m_rd_ready = 4'hF;
    step();
    m_rd_ready = 4'h0;
    check("os_ready_r2", 32'(rd_ready), 32'hF0);
    rd_valid = 8'h00;
    step();

    // Table: one grant round per vector from all-idle channels
    for (int v = 0; v < 10; v++) begin
      rd_valid = tv[v].req;
      step();
      check("tv_mem_valid", 32'(m_rd_valid), 32'(tv[v].exp_valid));
      exp_rdy = 8'h00;
      for (int c = 0; c < NCH; c++) begin
        if (tv[v].exp_valid[c]) begin
          check("tv_mem_addr", 32'(m_rd_addr[c]), 32'h40 + 32'(tv[v].id[c]));
          exp_rdy = exp_rdy | (8'(1) << tv[v].id[c]);
        end
        m_rd_data[c] = m_rd_addr[c] ^ 8'hA5;
      end
      m_rd_ready = m_rd_valid;
      step();
      m_rd_ready = 4'h0;
      check("tv_cons_ready", 32'(rd_ready), 32'(exp_rdy));
      for (int c = 0; c < NCH; c++)
        if (tv[v].exp_valid[c])
          check("tv_cons_data", 32'(rd_data[tv[v].id[c]]), 32'((8'h40 + 8'(tv[v].id[c])) ^ 8'hA5));
      rd_valid = 8'h00;
      step();
      check("tv_ready_drop", 32'(rd_ready), 32'h0);
    end

    // Read and write together on consumer 2: read first
    rd_addr[2] = 8'h30; wr_addr[2] = 8'h20; wr_data[2] = 8'h55;
    rd_valid = 8'h04; wr_valid = 8'h04;
    step();
    check("rw_rd_first", 32'({m_wr_valid, m_rd_valid}), 32'h01);
    check("rw_rd_addr", 32'(m_rd_addr[0]), 32'h30);
    m_rd_ready = 4'b0001; m_rd_data[0] = 8'h9C;
    step();
    m_rd_ready = 4'h0;
    check("rw_rd_ready", 32'({wr_ready, rd_ready}), 32'h0004);
    check("rw_rd_data", 32'(rd_data[2]), 32'h9C);
    rd_valid = 8'h00;
    step();
    check("rw_claim_held", 32'({m_wr_valid, rd_ready}), 32'h0);
    step();
    check("rw_wr_valid", 32'(m_wr_valid), 32'h1);
    check("rw_wr_addr", 32'(m_wr_addr[0]), 32'h20);
    check("rw_wr_data", 32'(m_wr_data[0]), 32'h55);
    m_wr_ready = 4'b0001;
    step();
    m_wr_ready = 4'h0;
    check("rw_wr_ready", 32'({m_wr_valid, wr_ready}), 32'h004);
    wr_valid = 8'h00;
    step();
    check("rw_wr_drop", 32'(wr_ready), 32'h0);
    rd_addr[2] = 8'h42;

    // Reset in READ_WAIT aborts and rewinds rr_ptr
    rd_valid = 8'h40;
    step();
    check("rm_granted", 32'(m_rd_valid), 32'h1);
    reset = 1'b1; rd_valid = 8'h00;
    #1;
    check("rm_async_valid", 32'({m_rd_valid, m_wr_valid}), 32'h0);
    check("rm_async_ready", 32'({rd_ready, wr_ready}), 32'h0);
    step();
    reset = 1'b0;
    rd_valid = 8'h81;
    step();
    check("rm_rr_zero_ch0", 32'(m_rd_addr[0]), 32'h40);
    check("rm_rr_zero_ch1", 32'(m_rd_addr[1]), 32'h47);
    m_rd_ready = 4'b0011;
    step();
    m_rd_ready = 4'h0;
    rd_valid = 8'h00;
    step();

    // Memory never answers
    rd_valid = 8'h02;
    step();
    check("to_granted", 32'(m_rd_valid), 32'h1);
    cnt = 0;
`ifdef ARB_TIMEOUT_EN
    while (cnt < 300 && !rd_ready[1]) begin
      step();
      cnt++;
    end
    check("to_wait_cycles", 32'(cnt), 32'd256);
    check("to_ready", 32'(rd_ready), 32'h02);
    check("to_data_zero", 32'(rd_data[1]), 32'h0);
    check("to_err_set", 32'(timeout_err), 32'h1);
    rd_valid = 8'h00;
    step(); step();
    check("to_err_sticky", 32'({timeout_err, rd_ready}), 32'h100);
`else
    while (cnt < 300) begin
      step();
      cnt++;
    end
    check("nto_still_waiting", 32'(m_rd_valid), 32'h1);
    check("nto_no_ready", 32'(rd_ready), 32'h0);
    check("nto_err_tied", 32'(timeout_err), 32'h0);
    rd_valid = 8'h00;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
